vga_pixel_filter: RTL and testbench

Per-pixel filter stage on `clk_vga`, directly downstream of the frame-buffer reader. It takes each 24-bit RGB888 pixel read from the frame BRAM, applies one of five switch-selected filters, and drives the 12-bit RGB444 VGA DAC. The pipeline is three cycles long, and the VGA counters are delayed alongside the pixel so the sync logic stays aligned. The filter mode changes only at frame start, so a frame is never shown with mixed filters.

---
 rtl/vga_pixel_filter.sv | 165 ++++++++++++++++
 tb/tb_vga_pixel_filter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_filter.sv
// vga_pixel_filter: per-pixel RGB888 filter (bypass/gray/invert/binary/edge) feeding a 12-bit RGB444 VGA DAC.
// Latency: 3 clk_vga cycles from pixel_in/hc_in/vc_in to vga_rgb/hc_out/vc_out; one pixel per cycle.
// Backpressure: none; free-running stream with no handshake and no stalls.
//
// Ports:
//   clk_vga, reset       pixel clock, synchronous active-high reset
//   hc_in, vc_in         visible counters (0 = blanking), aligned with pixel_in
//   pixel_in             {R,G,B} 8 bits each from the frame BRAM
//   filter_sel           raw asynchronous board switches
//   hc_out, vc_out       counters delayed to line up with vga_rgb
//   vga_rgb              {R,G,B} 4 bits each to the DAC
//   mode_active          filter mode in force for the current frame
// Optional feature: define VGA_PIXEL_FILTER_DITHER_EN for 2x2 Bayer dither before bit reduction.
module vga_pixel_filter #(
  parameter logic [7:0] EDGE_TH = 8'd32,
  parameter logic [7:0] BIN_TH  = 8'd128
) (
  input  logic        clk_vga,
  input  logic        reset,
  input  logic [10:0] hc_in,
  input  logic [10:0] vc_in,
  input  logic [23:0] pixel_in,
  input  logic [2:0]  filter_sel,
  output logic [10:0] hc_out,
  output logic [10:0] vc_out,
  output logic [11:0] vga_rgb,
  output logic [2:0]  mode_active
);

  localparam logic [2:0] MODE_GRAY   = 3'd1;
  localparam logic [2:0] MODE_INVERT = 3'd2;
  localparam logic [2:0] MODE_BINARY = 3'd3;
  localparam logic [2:0] MODE_EDGE   = 3'd4;

  // Switch synchroniser
  logic [2:0] sel_meta;
  logic [2:0] sel_sync;

  // Stage 1 registers
  logic [23:0] s1_pix;
  logic [10:0] s1_hc, s1_vc;
  logic [15:0] s1_pr, s1_pg, s1_pb;

  // Stage 2 registers
  logic [23:0] s2_pix;
  logic [23:0] s2_inv;
  logic [10:0] s2_hc, s2_vc;
  logic [7:0]  s2_y;

  // Luma of the previous visible pixel on the current line
  logic [7:0] y_prev;

  // Stage 1 combinational: luma weight products
  logic [15:0] pr_c, pg_c, pb_c;
  assign pr_c = 16'(pixel_in[23:16]) * 16'd77;
  assign pg_c = 16'(pixel_in[15:8])  * 16'd150;
  assign pb_c = 16'(pixel_in[7:0])   * 16'd29;

  // Stage 2 combinational: weights sum to 256, so the sum never exceeds 16 bits
  logic [7:0] y_c;
  assign y_c = 8'((s1_pr + s1_pg + s1_pb) >> 8);

  // Frame start seen on the stage-1 counters: the mode register then updates
  // one cycle before that pixel reaches the stage-3 mux, so the frame-start
  // pixel already uses the new mode.
  logic frame_start;
  assign frame_start = (s1_hc == 11'd1) && (s1_vc == 11'd1);

  // Stage 3 combinational
  logic       blank;
  logic [7:0] y_ref, y_diff;
  logic [23:0] filt;
  logic [7:0] out_r, out_g, out_b;

  assign blank = (s2_hc == 11'd0) || (s2_vc == 11'd0);
  // Column 1 compares against itself so a line never inherits the previous line's luma.
  assign y_ref  = (s2_hc == 11'd1) ? s2_y : y_prev;
  assign y_diff = (s2_y >= y_ref) ? (s2_y - y_ref) : (y_ref - s2_y);

  always_comb begin
    filt = s2_pix;
    case (mode_active)
      MODE_GRAY:   filt = {s2_y, s2_y, s2_y};
      MODE_INVERT: filt = s2_inv;
      MODE_BINARY: filt = (s2_y >= BIN_TH) ? 24'hFFFFFF : 24'h000000;
      MODE_EDGE:   filt = (y_diff >= EDGE_TH) ? 24'hFFFFFF : 24'h000000;
      default:     filt = s2_pix;
    endcase
  end

`ifdef VGA_PIXEL_FILTER_DITHER_EN
  // 2x2 Bayer offset keyed on the parity of the output coordinates.
  logic [7:0] dith_off;
  always_comb begin
    dith_off = 8'd0;
    case ({s2_vc[0], s2_hc[0]})
      2'b00:   dith_off = 8'd0;
      2'b01:   dith_off = 8'd8;
      2'b10:   dith_off = 8'd12;
      default: dith_off = 8'd4;
    endcase
  end

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [7:0] o);
    logic [8:0] s;
    s = {1'b0, c} + {1'b0, o};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign out_r = sat_add(filt[23:16], dith_off);
  assign out_g = sat_add(filt[15:8],  dith_off);
  assign out_b = sat_add(filt[7:0],   dith_off);
`else
  assign out_r = filt[23:16];
  assign out_g = filt[15:8];
  assign out_b = filt[7:0];
`endif

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      sel_meta    <= 3'd0;
      sel_sync    <= 3'd0;
      mode_active <= 3'd0;
      s1_pix      <= 24'd0;
      s1_hc       <= 11'd0;
      s1_vc       <= 11'd0;
      s1_pr       <= 16'd0;
      s1_pg       <= 16'd0;
      s1_pb       <= 16'd0;
      s2_pix      <= 24'd0;
      s2_inv      <= 24'd0;
      s2_hc       <= 11'd0;
      s2_vc       <= 11'd0;
      s2_y        <= 8'd0;
      y_prev      <= 8'd0;
      hc_out      <= 11'd0;
      vc_out      <= 11'd0;
      vga_rgb     <= 12'd0;
    end else begin
      sel_meta <= filter_sel;
      sel_sync <= sel_meta;
      if (frame_start) mode_active <= sel_sync;

      s1_pix <= pixel_in;
      s1_hc  <= hc_in;
      s1_vc  <= vc_in;
      s1_pr  <= pr_c;
      s1_pg  <= pg_c;
      s1_pb  <= pb_c;

      s2_pix <= s1_pix;
      s2_inv <= ~s1_pix;
      s2_hc  <= s1_hc;
      s2_vc  <= s1_vc;
      s2_y   <= y_c;

      if (!blank) y_prev <= s2_y;

      hc_out  <= s2_hc;
      vc_out  <= s2_vc;
      vga_rgb <= blank ? 12'h000 : {out_r[7:4], out_g[7:4], out_b[7:4]};
    end
  end

endmodule

// File: tb/tb_vga_pixel_filter.sv
// tb_vga_pixel_filter: table vectors, directed corner sequences and random frames against a pixel-level model.
// Latency: model expects each pixel's output three cycles after it is driven.
// Backpressure: none; the bench drives one pixel every cycle.
module tb_vga_pixel_filter;

  localparam int EDGE_TH = 32;
  localparam int BIN_TH  = 128;

  logic        clk_vga = 1'b0;
  logic        reset;
  logic [10:0] hc_in, vc_in;
  logic [23:0] pixel_in;
  logic [2:0]  filter_sel;
  logic [10:0] hc_out, vc_out;
  logic [11:0] vga_rgb;
  logic [2:0]  mode_active;

  vga_pixel_filter dut (
    .clk_vga     (clk_vga),
    .reset       (reset),
    .hc_in       (hc_in),
    .vc_in       (vc_in),
    .pixel_in    (pixel_in),
    .filter_sel  (filter_sel),
    .hc_out      (hc_out),
    .vc_out      (vc_out),
    .vga_rgb     (vga_rgb),
    .mode_active (mode_active)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic [11:0] rgb;
    logic [2:0]  mode;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [23:0] pix;
    logic [11:0] exp_plain;
    logic [11:0] exp_dith;   // dither offset 12 at (hc=2, vc=1)
  } vec_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  // model state
  int   m_mode = 0;
  int   m_prev = 0;
  logic [2:0] sel_prev = 3'd0;
  logic [2:0] cur_sel  = 3'd0;

  // observation helpers
  logic [10:0] cap_hc = 11'h7FF, cap_vc = 11'h7FF;
  logic [11:0] cap_rgb;
  int          edge_cnt = 0;
  int          edge_hc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  function automatic int luma(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
  endfunction

  function automatic logic [3:0] reduce(input int c, input int off);
    int v;
    v = c + off;
    if (v > 255) v = 255;
    return 4'(v / 16);
  endfunction

  function automatic int bayer(input logic [10:0] hc, input logic [10:0] vc);
`ifdef VGA_PIXEL_FILTER_DITHER_EN
    int tbl[4] = '{0, 8, 12, 4};
    return tbl[{vc[0], hc[0]}];
`else
    return 0;
`endif
  endfunction

  // One pixel per call: check the output due now, then drive and predict the next.
  task automatic step(input logic [10:0] hc, input logic [10:0] vc, input logic [23:0] pix);
    exp_t e;
    int   y, r, g, b, d, off;
    @(negedge clk_vga);
    if (q.size() == 3) begin
      e = q.pop_front();
      check("rgb", {20'd0, vga_rgb}, {20'd0, e.rgb});
      check("hc_out", {21'd0, hc_out}, {21'd0, e.hc});
      check("vc_out", {21'd0, vc_out}, {21'd0, e.vc});
      if (e.hc != 0 && e.vc != 0) check("mode", {29'd0, mode_active}, {29'd0, e.mode});
      if (e.hc == cap_hc && e.vc == cap_vc) cap_rgb = vga_rgb;
      if (vga_rgb == 12'hFFF) begin
        edge_cnt++;
        edge_hc = int'(hc_out);
      end
    end
    hc_in      = hc;
    vc_in      = vc;
    pixel_in   = pix;
    filter_sel = cur_sel;

    // switches seen by the mode latch lag one pixel behind the frame-start pixel
    if (hc == 1 && vc == 1) m_mode = int'(sel_prev);
    y = luma(pix);
    r = int'(pix[23:16]); g = int'(pix[15:8]); b = int'(pix[7:0]);
    case (m_mode)
      1: begin r = y; g = y; b = y; end
      2: begin r = 255 - r; g = 255 - g; b = 255 - b; end
      3: begin r = (y >= BIN_TH) ? 255 : 0; g = r; b = r; end
      4: begin
        d = (hc == 1) ? 0 : ((y > m_prev) ? y - m_prev : m_prev - y);
        r = (d >= EDGE_TH) ? 255 : 0; g = r; b = r;
      end
      default: ;
    endcase
    e.hc = hc; e.vc = vc; e.mode = 3'(m_mode);
    if (hc == 0 || vc == 0) e.rgb = 12'h000;
    else begin
      off   = bayer(hc, vc);
      e.rgb = {reduce(r, off), reduce(g, off), reduce(b, off)};
      m_prev = y;
    end
    q.push_back(e);
    sel_prev = cur_sel;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_vga);
    reset = 1'b1; hc_in = 11'd5; vc_in = 11'd5; pixel_in = 24'hFFFFFF; filter_sel = 3'd3;
    repeat (n) begin
      @(negedge clk_vga);
      check("rst_rgb",  {20'd0, vga_rgb},     32'd0);
      check("rst_hc",   {21'd0, hc_out},      32'd0);
      check("rst_vc",   {21'd0, vc_out},      32'd0);
      check("rst_mode", {29'd0, mode_active}, 32'd0);
    end
    reset = 1'b0; hc_in = 11'd0; vc_in = 11'd0; pixel_in = 24'd0; filter_sel = cur_sel;
    q.delete();
    m_mode = 0; m_prev = 0; sel_prev = cur_sel;
  endtask

  task automatic vblank();
    repeat (3) step(11'd0, 11'd0, 24'd0);
  endtask

  task automatic line(input int vc, input int w, input logic [23:0] pix, input bit rnd);
    logic [23:0] p;
    step(11'd0, 11'(vc), 24'd0);
    step(11'd0, 11'(vc), 24'd0);
    for (int h = 1; h <= w; h++) begin
      p = rnd ? 24'($urandom) : pix;
      if (rnd && h == 5 && $urandom_range(0, 2) == 0) cur_sel = 3'($urandom_range(0, 7));
      step(11'(h), 11'(vc), p);
    end
  endtask

  task automatic frame(input int w, input int h, input logic [23:0] pix, input bit rnd);
    vblank();
    for (int v = 1; v <= h; v++) line(v, w, pix, rnd);
  endtask

  // Drive one pixel, then blanks until its output has been observed.
  task automatic cap_check(input string name, input int hc, input int vc,
                           input logic [23:0] pix, input logic [11:0] req);
    cap_hc = 11'(hc); cap_vc = 11'(vc); cap_rgb = 12'hXXX;
    step(11'(hc), 11'(vc), pix);
    repeat (3) step(11'd0, 11'(vc), 24'd0);
    check(name, {20'd0, cap_rgb}, {20'd0, req});
    cap_hc = 11'h7FF; cap_vc = 11'h7FF;
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{3'd0, 24'h123456, 12'h135, 12'h146};
    tbl[1]  = '{3'd1, 24'hFF0000, 12'h444, 12'h555};
    tbl[2]  = '{3'd1, 24'hFFFFFF, 12'hFFF, 12'hFFF};
    tbl[3]  = '{3'd2, 24'h0F0F0F, 12'hFFF, 12'hFFF};
    tbl[4]  = '{3'd0, 24'h0F0F0F, 12'h000, 12'h111};
    tbl[5]  = '{3'd3, 24'h808080, 12'hFFF, 12'hFFF};
    tbl[6]  = '{3'd3, 24'h7F7F7F, 12'h000, 12'h000};
    tbl[7]  = '{3'd4, 24'h808080, 12'h000, 12'h000};
    tbl[8]  = '{3'd5, 24'h123456, 12'h135, 12'h146};
    tbl[9]  = '{3'd7, 24'hABCDEF, 12'hACE, 12'hBDF};
    tbl[10] = '{3'd2, 24'h123456, 12'hECA, 12'hFDB};

    reset = 1'b1; hc_in = 11'd0; vc_in = 11'd0; pixel_in = 24'd0; filter_sel = 3'd0;
    cur_sel = 3'd0;
    do_reset(4);

    // constant pixel in bypass
    frame(8, 2, 24'h123456, 1'b0);
    vblank();
    step(11'd1, 11'd1, 24'h123456);
`ifdef VGA_PIXEL_FILTER_DITHER_EN
    cap_check("bypass_123456", 2, 1, 24'h123456, 12'h146);
`else
    cap_check("bypass_123456", 2, 1, 24'h123456, 12'h135);
`endif

    // table vectors: new mode at frame start, observe column 2
    for (int i = 0; i < 11; i++) begin
      cur_sel = tbl[i].sel;
      vblank();
      step(11'd1, 11'd1, tbl[i].pix);
`ifdef VGA_PIXEL_FILTER_DITHER_EN
      cap_check($sformatf("tbl%0d", i), 2, 1, tbl[i].pix, tbl[i].exp_dith);
`else
      cap_check($sformatf("tbl%0d", i), 2, 1, tbl[i].pix, tbl[i].exp_plain);
`endif
    end

    // mid-frame switch 0 -> 2 holds until the next frame start
    cur_sel = 3'd0;
    frame(8, 1, 24'h0F0F0F, 1'b0);
    step(11'd0, 11'd2, 24'd0);
    step(11'd0, 11'd2, 24'd0);
    for (int h = 1; h <= 8; h++) begin
      if (h == 4) cur_sel = 3'd2;
      step(11'(h), 11'd2, 24'h0F0F0F);
    end
    line(3, 8, 24'h0F0F0F, 1'b0);
    check("mode_hold", {29'd0, mode_active}, 32'd0);
    vblank();
    step(11'd1, 11'd1, 24'h0F0F0F);
    cap_check("switch_new_frame", 2, 1, 24'h0F0F0F, 12'hFFF);
    check("mode_new", {29'd0, mode_active}, 32'd2);

    // edge: one line of Y=10 then Y=60 from column 512
    cur_sel = 3'd4;
    vblank();
    edge_cnt = 0; edge_hc = 0;
    step(11'd0, 11'd1, 24'd0);
    step(11'd0, 11'd1, 24'd0);
    for (int h = 1; h <= 600; h++) step(11'(h), 11'd1, (h < 512) ? 24'h0A0A0A : 24'h3C3C3C);
    step(11'd0, 11'd2, 24'd0);
    step(11'd0, 11'd2, 24'd0);
    cap_check("edge_col1", 1, 2, 24'hFFFFFF, 12'h000);
    check("edge_count", edge_cnt, 1);
    check("edge_col", edge_hc, 512);

    // blanking in every mode
    for (int s = 0; s < 8; s++) begin
      cur_sel = 3'(s);
      vblank();
      step(11'd1, 11'd1, 24'hFFFFFF);
      cap_check($sformatf("blank_m%0d", s), 0, 1, 24'hFFFFFF, 12'h000);
    end

    // dither parity cases in bypass
    cur_sel = 3'd0;
    vblank();
    step(11'd1, 11'd1, 24'h7C7C7C);
    cap_check("dith_p00", 2, 2, 24'h7C7C7C, 12'h777);
`ifdef VGA_PIXEL_FILTER_DITHER_EN
    cap_check("dith_p10", 2, 1, 24'h7C7C7C, 12'h888);
`else
    cap_check("dith_p10", 2, 1, 24'h7C7C7C, 12'h777);
`endif
    cap_check("dith_sat", 2, 1, 24'hFAFAFA, 12'hFFF);

    // reset mid-frame forces bypass until the next frame start
    cur_sel = 3'd2;
    vblank();
    step(11'd1, 11'd1, 24'h0F0F0F);
    step(11'd2, 11'd1, 24'h0F0F0F);
    do_reset(2);
    for (int h = 3; h <= 6; h++) step(11'(h), 11'd1, 24'h0F0F0F);
    repeat (3) step(11'd0, 11'd1, 24'd0);
    check("rst_bypass", {29'd0, mode_active}, 32'd0);
    vblank();
    step(11'd1, 11'd1, 24'h0F0F0F);
    cap_check("rst_new_frame", 2, 1, 24'h0F0F0F, 12'hFFF);

    // random frames
    for (int f = 0; f < 6; f++) begin
      if (f % 2 == 0) cur_sel = 3'($urandom_range(0, 7));
      frame(20, 4, 24'd0, 1'b1);
    end
    vblank();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
